// File: rtl/cgra_pkg.sv
// CGRA-wide constants plus the types used by the node-to-bus round-robin arbiter.
package cgra_pkg;

  localparam int unsigned NODES    = 4;
  localparam int unsigned ARB_ID_W = (NODES > 1) ? $clog2(NODES) : 1;

  typedef logic [ARB_ID_W-1:0] arb_id_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by every bus master and slave in the CGRA subsystem.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/cgra_obi_id_fifo.sv
// In-order queue of port IDs for accepted OBI requests; head names the port owed the next rvalid.
module cgra_obi_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= next_ptr(wr_q);
      if (do_pop)  rd_q <= next_ptr(rd_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/cgra_obi_rr_arbiter.sv
// Round-robin arbiter folding NUM_PORTS CGRA node OBI masters onto one bus master port.
// state   | meaning
// ST_IDLE | selection follows the round-robin search from ptr_q
// ST_LOCK | request issued without gnt; selection frozen in sel_q until the handshake
module cgra_obi_rr_arbiter
  import obi_pkg::*;
  import cgra_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = NODES,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  slaves_req_i  [NUM_PORTS],
  output obi_resp_t slaves_resp_o [NUM_PORTS],
  output obi_req_t  master_req_o,
  input  obi_resp_t master_resp_i,
  output logic      busy_o,
  output logic      err_o
);

  localparam int unsigned IDW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  typedef logic [IDW-1:0] id_t;

  arb_state_e state_q, state_d;
  id_t        ptr_q, ptr_d, sel_q, sel_d;
  id_t        sel, sel_arb, head;
  logic       err_q, err_d;
  logic       found, has_req, hs, push, pop, full, empty;
  int         idx;

  always_comb begin
    found   = 1'b0;
    sel_arb = '0;
    idx     = 0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= int'(NUM_PORTS)) idx = idx - int'(NUM_PORTS);
      if (!found && slaves_req_i[id_t'(idx)].req) begin
        found   = 1'b1;
        sel_arb = id_t'(idx);
      end
    end
  end

  always_comb begin
    sel     = (state_q == ST_LOCK) ? sel_q : sel_arb;
    has_req = (state_q == ST_LOCK) || found;

    master_req_o = '0;
    if (has_req) master_req_o = slaves_req_i[sel];
    // Full gating uses registered count only, so rvalid never reaches req combinationally.
    if (full) master_req_o.req = 1'b0;

    hs   = master_req_o.req & master_resp_i.gnt;
    push = hs;
    pop  = master_resp_i.rvalid & ~empty;

    for (int p = 0; p < int'(NUM_PORTS); p++) slaves_resp_o[p] = '0;
    slaves_resp_o[sel].gnt = hs;
    if (pop) begin
      slaves_resp_o[head].rvalid = 1'b1;
      slaves_resp_o[head].rdata  = master_resp_i.rdata;
    end

    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (hs) begin
      state_d = ST_IDLE;
      ptr_d   = (sel == id_t'(NUM_PORTS - 1)) ? '0 : sel + id_t'(1);
    end else if (master_req_o.req) begin
      state_d = ST_LOCK;
      sel_d   = sel;
    end else begin
      state_d = ST_IDLE;
    end

    err_d = err_q | (master_resp_i.rvalid & empty);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  cgra_obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (sel),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign busy_o = ~empty | (state_q == ST_LOCK);
  assign err_o  = err_q;

endmodule

// File: tb/tb_cgra_obi_rr_arbiter.sv
// Directed-vector bench for cgra_obi_rr_arbiter (4 ports, 2 outstanding).
module tb_cgra_obi_rr_arbiter;
  import obi_pkg::*;

  localparam int NP = 4;

  logic      clk = 1'b0;
  logic      rst;
  obi_req_t  sreq  [NP];
  obi_resp_t sresp [NP];
  obi_req_t  mreq;
  obi_resp_t mresp;
  logic      busy, err;

  int n_vec = 0;
  int n_err = 0;

  cgra_obi_rr_arbiter #(.NUM_PORTS(NP), .MAX_OUTSTANDING(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .slaves_req_i  (sreq),
    .slaves_resp_o (sresp),
    .master_req_o  (mreq),
    .master_resp_i (mresp),
    .busy_o        (busy),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int p);
    return 32'h1000 + 32'(p) * 32'h10;
  endfunction

  function automatic logic [31:0] gvec();
    logic [31:0] v = '0;
    for (int p = 0; p < NP; p++) v[p] = sresp[p].gnt;
    return v;
  endfunction

  function automatic logic [31:0] rvec();
    logic [31:0] v = '0;
    for (int p = 0; p < NP; p++) v[p] = sresp[p].rvalid;
    return v;
  endfunction

  task automatic drive(input logic [3:0] reqv, input logic gnt, input logic rv, input logic [31:0] rd);
    for (int p = 0; p < NP; p++) begin
      sreq[p].req   = reqv[p];
      sreq[p].addr  = addr_of(p);
      sreq[p].we    = p[0];
      sreq[p].be    = 4'hf;
      sreq[p].wdata = 32'hA0 + 32'(p);
    end
    mresp.gnt    = gnt;
    mresp.rvalid = rv;
    mresp.rdata  = rd;
  endtask

  // Drive a new input vector shortly after the edge, then leave time for combinational settling.
  task automatic cyc(input logic [3:0] reqv, input logic gnt, input logic rv, input logic [31:0] rd);
    @(posedge clk); #1;
    drive(reqv, gnt, rv, rd);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive(4'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(4'h0, 1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_mreq_req", 32'(mreq.req), 32'd0);
    check("rst_mreq_addr", mreq.addr, 32'h0);
    check("rst_gnt", gvec(), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // All four ports request, bus grants every cycle, rvalid follows each grant by one cycle.
    cyc(4'hF, 1'b1, 1'b0, 32'h0);
    check("rr0_gnt", gvec(), 32'h1);
    check("rr0_addr", mreq.addr, addr_of(0));
    check("rr0_rv", rvec(), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      int g, pv;
      g  = k % NP;
      pv = (k - 1) % NP;
      cyc(4'hF, 1'b1, 1'b1, 32'hD0 + 32'(pv));
      check("rr_gnt", gvec(), 32'h1 << g);
      check("rr_addr", mreq.addr, addr_of(g));
      check("rr_rv", rvec(), 32'h1 << pv);
      check("rr_rdata", sresp[pv].rdata, 32'hD0 + 32'(pv));
      check("rr_rdata_other", sresp[g].rdata, 32'h0);
      check("rr_busy", 32'(busy), 32'd1);
    end
    cyc(4'h0, 1'b1, 1'b1, 32'hD0);
    check("rr_tail_gnt", gvec(), 32'h0);
    check("rr_tail_rv", rvec(), 32'h1);
    check("rr_tail_rdata", sresp[0].rdata, 32'hD0);
    check("idle_req", 32'(mreq.req), 32'd0);
    check("idle_addr", mreq.addr, 32'h0);
    cyc(4'h0, 1'b0, 1'b0, 32'h0);
    check("rr_done_busy", 32'(busy), 32'd0);
    check("rr_done_err", 32'(err), 32'd0);

    // Port 2 waits three cycles for gnt; port 1 joins but must not steal the locked selection.
    do_reset();
    cyc(4'b0100, 1'b0, 1'b0, 32'h0);
    check("lk0_addr", mreq.addr, addr_of(2));
    check("lk0_gnt", gvec(), 32'h0);
    cyc(4'b0110, 1'b0, 1'b0, 32'h0);
    check("lk1_addr", mreq.addr, addr_of(2));
    check("lk1_busy", 32'(busy), 32'd1);
    cyc(4'b0110, 1'b0, 1'b0, 32'h0);
    check("lk2_addr", mreq.addr, addr_of(2));
    cyc(4'b0110, 1'b1, 1'b0, 32'h0);
    check("lk3_gnt", gvec(), 32'h4);
    check("lk3_addr", mreq.addr, addr_of(2));
    cyc(4'b0010, 1'b1, 1'b0, 32'h0);
    check("lk4_gnt", gvec(), 32'h2);
    check("lk4_addr", mreq.addr, addr_of(1));
    cyc(4'h0, 1'b0, 1'b1, 32'hBEEF0002);
    check("lk_rv_a", rvec(), 32'h4);
    check("lk_rd_a", sresp[2].rdata, 32'hBEEF0002);
    cyc(4'h0, 1'b0, 1'b1, 32'hBEEF0001);
    check("lk_rv_b", rvec(), 32'h2);
    check("lk_rd_b", sresp[1].rdata, 32'hBEEF0001);

    // Two outstanding fills the ID FIFO; a pop only re-opens requests on the following cycle.
    do_reset();
    cyc(4'hF, 1'b1, 1'b0, 32'h0);
    check("fl0_gnt", gvec(), 32'h1);
    cyc(4'hF, 1'b1, 1'b0, 32'h0);
    check("fl1_gnt", gvec(), 32'h2);
    cyc(4'hF, 1'b1, 1'b0, 32'h0);
    check("fl2_req", 32'(mreq.req), 32'd0);
    check("fl2_gnt", gvec(), 32'h0);
    check("fl2_busy", 32'(busy), 32'd1);
    cyc(4'hF, 1'b1, 1'b1, 32'h11);
    check("fl3_req", 32'(mreq.req), 32'd0);
    check("fl3_rv", rvec(), 32'h1);
    cyc(4'hF, 1'b1, 1'b0, 32'h0);
    check("fl4_req", 32'(mreq.req), 32'd1);
    check("fl4_gnt", gvec(), 32'h4);
    cyc(4'h0, 1'b0, 1'b1, 32'h22);
    check("fl5_rv", rvec(), 32'h2);
    cyc(4'h0, 1'b0, 1'b1, 32'h33);
    check("fl6_rv", rvec(), 32'h4);
    check("fl6_rd", sresp[2].rdata, 32'h33);

    // Stray rvalid with nothing outstanding.
    do_reset();
    cyc(4'h0, 1'b0, 1'b1, 32'h55);
    check("er0_rv", rvec(), 32'h0);
    cyc(4'h0, 1'b0, 1'b0, 32'h0);
    check("er1_err", 32'(err), 32'd1);
    repeat (3) cyc(4'h0, 1'b0, 1'b0, 32'h0);
    check("er_sticky", 32'(err), 32'd1);
    do_reset();
    check("er_cleared", 32'(err), 32'd0);

    // Reset with two transactions in flight.
    cyc(4'hF, 1'b1, 1'b0, 32'h0);
    cyc(4'hF, 1'b1, 1'b0, 32'h0);
    cyc(4'h0, 1'b0, 1'b0, 32'h0);
    check("mr_busy_pre", 32'(busy), 32'd1);
    do_reset();
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_err", 32'(err), 32'd0);
    cyc(4'b1010, 1'b1, 1'b1, 32'h77);
    check("mr_ptr0_gnt", gvec(), 32'h2);
    check("mr_stale_rv", rvec(), 32'h0);
    cyc(4'b1000, 1'b1, 1'b0, 32'h0);
    check("mr_p3_gnt", gvec(), 32'h8);
    check("mr_err_set", 32'(err), 32'd1);

    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
